// File: rtl/servant_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servant_uart_tx: Wishbone byte-write UART transmitter (8N1) with TX FIFO  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module servant_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_tx, w_tx_nxt;
    logic            w_pop;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW:0]   r_wptr, r_rptr;
    logic            r_ack, r_ovf;
    logic [31:0]     r_rdt, w_status;

    logic [c_AW:0]   w_level;
    logic            w_full, w_empty, w_req, w_wr_data, w_push, w_clr_ovf;
    logic            w_unused;

    assign w_unused  = &{1'b0, i_wb_dat[31:8], i_wb_sel[3:1]};

    assign w_level   = r_wptr - r_rptr;
    assign w_full    = (w_level == c_DEPTH);
    assign w_empty   = (w_level == '0);
    assign w_req     = i_wb_cyc & ~r_ack;
    assign w_wr_data = w_req & i_wb_we & ~i_wb_adr & i_wb_sel[0];
    assign w_push    = w_wr_data & ~w_full;
    assign w_clr_ovf = w_req & i_wb_we & i_wb_adr & i_wb_dat[3];

    always_comb begin
        w_status             = 32'h0;
        w_status[0]          = (r_state != S_IDLE);
        w_status[1]          = w_full;
        w_status[2]          = w_empty;
        w_status[3]          = r_ovf;
        w_status[8 +: c_AW+1] = w_level;
    end

    // Bus side: ack, read data, overflow flag and FIFO write pointer
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_ack  <= 1'b0;
            r_rdt  <= 32'h0;
            r_ovf  <= 1'b0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_ack <= w_req;
            r_rdt <= (w_req && !i_wb_we && i_wb_adr) ? w_status : 32'h0;
            if (w_wr_data && w_full)
                r_ovf <= 1'b1;
            else if (w_clr_ovf)
                r_ovf <= 1'b0;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (w_push)
            r_mem[r_wptr[c_AW-1:0]] <= i_wb_dat[7:0];
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Pops only look at pre-edge emptiness, so a same-edge push is never seen here
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr[c_AW-1:0]];
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7)
                        w_state_nxt = S_STOP;
                    else
                        w_idx_nxt = r_idx + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_cnt_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rptr[c_AW-1:0]];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line level registered from the next state so o_tx is glitch-free
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign o_wb_ack = r_ack;
    assign o_wb_rdt = r_rdt;
    assign o_tx     = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_servant_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_servant_uart_tx: randomized bench with frame-level reference model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_servant_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        wb_adr = 1'b0;
    logic [31:0] wb_dat = 32'h0;
    logic [3:0]  wb_sel = 4'h0;
    logic        wb_we  = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] rdt;
    logic        ack;
    logic        tx;

    always #5 clk = ~clk;

    servant_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_adr   (wb_adr),
        .i_wb_dat   (wb_dat),
        .i_wb_sel   (wb_sel),
        .i_wb_we    (wb_we),
        .i_wb_cyc   (wb_cyc),
        .o_wb_rdt   (rdt),
        .o_wb_ack   (ack),
        .o_tx       (tx)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "current frame and time into it"
    logic [7:0]  m_q [$];
    bit          m_busy = 1'b0;
    int          m_t    = 0;
    bit          m_ovf  = 1'b0;
    bit          m_ack  = 1'b0;
    logic [31:0] m_rdt  = 32'h0;
    logic [7:0]  m_byte = 8'h0;

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    initial begin
        int          pre_lvl;
        bit          req;
        bit          pop;
        logic [31:0] st;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_busy = 1'b0; m_t = 0; m_ovf = 1'b0;
                m_ack = 1'b0; m_rdt = 32'h0;
            end else begin
                pre_lvl = m_q.size();
                req     = wb_cyc && !m_ack;
                st      = 32'(pre_lvl) << 8;
                st[0]   = m_busy;
                st[1]   = (pre_lvl == DEPTH);
                st[2]   = (pre_lvl == 0);
                st[3]   = m_ovf;
                pop     = 1'b0;
                if (m_busy) begin
                    m_t++;
                    if (m_t == FRAME) begin
                        if (pre_lvl > 0) pop = 1'b1;
                        else begin m_busy = 1'b0; m_t = 0; end
                    end
                end else if (pre_lvl > 0) begin
                    pop = 1'b1;
                end
                if (pop) begin
                    m_byte = m_q.pop_front();
                    m_busy = 1'b1;
                    m_t    = 0;
                end
                m_rdt = 32'h0;
                if (req) begin
                    if (wb_we && !wb_adr && wb_sel[0]) begin
                        if (pre_lvl == DEPTH) m_ovf = 1'b1;
                        else m_q.push_back(wb_dat[7:0]);
                    end
                    if (wb_we && wb_adr && wb_dat[3]) m_ovf = 1'b0;
                    if (!wb_we && wb_adr) m_rdt = st;
                end
                m_ack = req;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("tx_line", {31'h0, tx}, {31'h0, exp_tx()});
            check("wb_ack", {31'h0, ack}, {31'h0, m_ack});
            check("wb_rdt", rdt, m_rdt);
        end
    end

    // Independent line receiver: decodes bytes by mid-bit sampling
    logic [7:0] rx_q [$];
    int         rx_start [$];
    int         cyc_n = 0;

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    initial begin
        bit         act = 1'b0;
        int         cnt = 0;
        logic [7:0] sh  = 8'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx == 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                    rx_start.push_back(cyc_n);
                end
            end else begin
                cnt++;
                for (int k = 1; k <= 8; k++)
                    if (cnt == CPB*k + CPB/2) sh[k-1] = tx;
                if (cnt == CPB*9 + CPB/2) begin
                    check("rx_stop_bit", {31'h0, tx}, 32'h1);
                    rx_q.push_back(sh);
                end
                if (cnt == FRAME - 1) act = 1'b0;
            end
        end
    end

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    // One bus access; entered just after a falling clock edge, returns on one
    task automatic wb(input logic adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
        bit got;
        got    = 1'b0;
        rd     = 32'h0;
        wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel; wb_cyc = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                rd  = rdt;
            end
        end
        check("ack_seen", {31'h0, got}, 32'h1);
        @(negedge clk);
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  sent [$];
        int          n0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_ack", {31'h0, ack}, 32'h0);
        wb(1'b1, 1'b0, 32'h0, 4'hF, r);
        check("reset_status", r, 32'h0000_0004);

        // Single byte: line falls one edge after the ack edge
        rx_q.delete();
        wb(1'b0, 1'b1, 32'h55, 4'h1, r);
        check("tx_before_pop", {31'h0, tx}, 32'h1);
        @(posedge clk);
        #1 check("tx_fall", {31'h0, tx}, 32'h0);
        repeat (FRAME + 6) @(negedge clk);
        check("single_count", rx_q.size(), 1);
        check("single_byte", {24'h0, rx_at(0)}, 32'h55);
        wb(1'b1, 1'b0, 32'h0, 4'hF, r);
        check("single_idle_status", r, 32'h0000_0004);

        // Back-to-back frames
        rx_q.delete();
        rx_start.delete();
        wb(1'b0, 1'b1, 32'hA3, 4'h1, r);
        wb(1'b0, 1'b1, 32'h0F, 4'h1, r);
        repeat (2 * FRAME + 10) @(negedge clk);
        check("b2b_count", rx_q.size(), 2);
        check("b2b_byte0", {24'h0, rx_at(0)}, 32'hA3);
        check("b2b_byte1", {24'h0, rx_at(1)}, 32'h0F);
        check("b2b_gap", (rx_start.size() == 2) ? rx_start[1] - rx_start[0] : -1, FRAME);

        // Overflow with six writes inside the first frame
        rx_q.delete();
        for (int i = 1; i <= 6; i++)
            wb(1'b0, 1'b1, 32'(i), 4'h1, r);
        wb(1'b1, 1'b0, 32'h0, 4'hF, r);
        check("ovf_status", r, 32'h0000_040B);
        wb(1'b1, 1'b1, 32'h8, 4'h1, r);
        wb(1'b1, 1'b0, 32'h0, 4'hF, r);
        check("ovf_cleared_status", r, 32'h0000_0403);
        repeat (5 * FRAME + 20) @(negedge clk);
        check("ovf_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check("ovf_byte", {24'h0, rx_at(i)}, 32'(i + 1));

        // Wrap-around: 3*DEPTH random bytes, paced below the drain rate
        rx_q.delete();
        sent.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            wb(1'b0, 1'b1, {24'($urandom), b}, 4'h1, r);
            repeat ($urandom_range(FRAME - 5, FRAME + 20)) @(negedge clk);
        end
        repeat (3 * FRAME) @(negedge clk);
        check("wrap_count", rx_q.size(), 3 * DEPTH);
        for (int i = 0; i < 3 * DEPTH; i++)
            check("wrap_byte", {24'h0, rx_at(i)}, {24'h0, sent[i]});
        wb(1'b1, 1'b0, 32'h0, 4'hF, r);
        check("wrap_status", r, 32'h0000_0004);

        // Random mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 150; i++) begin
            wb(1'($urandom), 1'($urandom), $urandom, 4'($urandom), r);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wb(1'b1, 1'b1, 32'h8, 4'h0, r);
        repeat (6 * FRAME) @(negedge clk);

        // Reset during DATA bit 3 of 0xC5 (bit 3 is 0)
        wb(1'b0, 1'b1, 32'hC5, 4'h1, r);
        repeat (17) @(negedge clk);
        check("bit3_low", {31'h0, tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1 check("reset_tx_async", {31'h0, tx}, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        n0 = rx_q.size();
        @(negedge clk);
        repeat (2 * FRAME) @(negedge clk);
        check("no_residual_frame", rx_q.size(), n0);
        wb(1'b1, 1'b0, 32'h0, 4'hF, r);
        check("post_reset_status", r, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
